// File: rtl/load_extend_pkg.sv
// Shared load-path definitions: access-size encodings used by the decoder,
// the memory stage and the load aligner.
package load_extend_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Access size in bytes for a size encoding.
  function automatic int size_bytes(input logic [1:0] sz);
    return 32'sd1 << sz;
  endfunction

endpackage

// File: rtl/load_extend_core.sv
// Combinational load aligner: shifts the addressed lane down, keeps the
// accessed field, sign/zero extends it and flags illegal or misaligned accesses.
module load_extend_core
  import load_extend_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [OFF_W-1:0]  offset_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misalign_o
);

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] keep;
  logic              top_bit;
  int                nbytes;

  // Bits outside the kept field take the fill value; a full-width field has
  // an all-ones keep mask, so no extension is applied there.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] field,
                                               input logic [DATA_W-1:0] mask,
                                               input logic              fill);
    return (field & mask) | (fill ? ~mask : '0);
  endfunction

  always_comb begin
    lane    = data_i >> {offset_i, 3'b000};
    nbytes  = size_bytes(size_i);
    keep    = '1;
    top_bit = lane[DATA_W-1];
    case (size_e'(size_i))
      SZ_BYTE: begin
        keep    = DATA_W'(8'hFF);
        top_bit = lane[7];
      end
      SZ_HALF: begin
        keep    = DATA_W'(16'hFFFF);
        top_bit = lane[15];
      end
      SZ_WORD: begin
        keep    = DATA_W'(32'hFFFF_FFFF);
        top_bit = lane[31];
      end
      default: begin
        keep    = '1;
        top_bit = lane[DATA_W-1];
      end
    endcase
    misalign_o = ((32'(offset_i) & 32'(nbytes - 1)) != 32'd0) ||
                 (nbytes * 8 > DATA_W);
    data_o     = misalign_o ? '0 : extend(lane, keep, sign_i && top_bit);
  end

endmodule

// File: rtl/load_extend.sv
// Load align/extend stage: one-cycle registered result with a one-entry skid
// buffer so in_ready never depends combinationally on out_ready.
module load_extend
  import load_extend_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [1:0]        in_size,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign
);

  logic [DATA_W-1:0] core_data;
  logic              core_mis;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              main_mis_q, main_mis_d;
  logic              skid_mis_q, skid_mis_d;

  logic              accept;
  logic              main_free;

  load_extend_core #(.DATA_W(DATA_W)) u_core (
    .data_i     (in_data),
    .offset_i   (in_offset),
    .size_i     (in_size),
    .sign_i     (in_sign),
    .data_o     (core_data),
    .misalign_o (core_mis)
  );

  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid_q || out_ready;

  // main refills from skid first to keep order; skid only fills while main stalls
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    main_mis_d   = main_mis_q;
    skid_data_d  = skid_data_q;
    skid_mis_d   = skid_mis_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_mis_d   = skid_mis_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = core_data;
        main_mis_d   = core_mis;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = core_data;
      skid_mis_d   = core_mis;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    main_mis_q  <= main_mis_d;
    skid_data_q <= skid_data_d;
    skid_mis_q  <= skid_mis_d;
  end

  // Gating by valid gives zero outputs during reset without resetting data.
  assign out_valid    = main_valid_q;
  assign out_data     = main_valid_q ? main_data_q : '0;
  assign out_misalign = main_valid_q && main_mis_q;

endmodule
